// File: rtl/uart_tx_model_pkg.sv
// cep_uart_pkg: shared types and helpers for the testbench UART transmitter.
// Holds the frame state enum, idle line level and cycles-per-bit helper.
package cep_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  localparam logic UART_IDLE_LEVEL = 1'b1;

  function automatic int cycles_per_bit(
    input int clk_hz,
    input int bit_rate
  );
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_tx_model_if.sv
// uart_tx_model_if: valid/ready byte push port of the UART transmitter.
// master drives bytes in, slave (the transmitter) reports FIFO space.
interface uart_tx_model_if #(
  parameter int PAYLOAD_BITS = 8
);

  logic                    wr_valid;
  logic [PAYLOAD_BITS-1:0] wr_data;
  logic                    wr_ready;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/uart_tx_model_byte_fifo.sv
// uart_tx_byte_fifo: small synchronous FIFO, head data visible combinationally.
// Pointers wrap by masking; full/empty come from the registered count.
module uart_tx_byte_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PMASK = AW'(DEPTH - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next pointers and occupancy; push+pop together leaves count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q + AW'(1)) & PMASK;
    if (do_pop)  rd_ptr_d = (rd_ptr_q + AW'(1)) & PMASK;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array, written on accepted push only.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointer and count registers, flushed by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_model.sv
// uart_tx_model: FIFO-fed serial transmitter, frames sent back to back.
// Define UART_TX_MODEL_PARITY_EN to add an even-parity bit after the data.
module uart_tx_model
  import cep_uart_pkg::*;
#(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 50_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          tx_en,
  uart_tx_model_if.slave                wr,
  output logic                          uart_txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CPB = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int TW  = $clog2(CPB);
  localparam int BW  = $clog2(PAYLOAD_BITS + 1);
  localparam logic [TW-1:0] T_LAST = TW'(CPB - 1);
  localparam logic [BW-1:0] D_LAST = BW'(PAYLOAD_BITS - 1);
  localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);

  uart_tx_state_t state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic                    txd_q, txd_d;
  logic                    busy_q, busy_d;
`ifdef UART_TX_MODEL_PARITY_EN
  logic                    par_q, par_d;
`endif

  logic                    pop;
  logic                    full;
  logic                    empty;
  logic                    bit_end;
  logic                    next_frame;
  logic [PAYLOAD_BITS-1:0] rd_data;

  uart_tx_byte_fifo #(
    .W     (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr.wr_valid),
    .wdata (wr.wr_data),
    .pop   (pop),
    .rdata (rd_data),
    .count (fifo_count),
    .full  (full),
    .empty (empty)
  );

  assign wr.wr_ready = !full;
  assign bit_end     = (timer_q == T_LAST);
  assign uart_txd    = txd_q;
  assign busy        = busy_q;

  // Frame sequencing; a new frame can start from IDLE or straight from STOP.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    pop        = 1'b0;
    next_frame = 1'b0;
`ifdef UART_TX_MODEL_PARITY_EN
    par_d      = par_q;
`endif
    if (state_q != IDLE) begin
      timer_d = bit_end ? '0 : timer_q + TW'(1);
    end
    unique case (state_q)
      IDLE: begin
        next_frame = tx_en && !empty;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == D_LAST) begin
            bit_d   = '0;
`ifdef UART_TX_MODEL_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef UART_TX_MODEL_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          bit_d   = '0;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (bit_q == S_LAST) begin
            bit_d      = '0;
            state_d    = IDLE;
            next_frame = tx_en && !empty;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (next_frame) begin
      pop     = 1'b1;
      shift_d = rd_data;
      timer_d = '0;
      bit_d   = '0;
      state_d = START;
`ifdef UART_TX_MODEL_PARITY_EN
      par_d   = ^rd_data;
`endif
    end
  end

  // Line level for the current state, registered one cycle later.
  always_comb begin
    txd_d  = UART_IDLE_LEVEL;
    busy_d = (state_q != IDLE);
    unique case (state_q)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_q[0];
`ifdef UART_TX_MODEL_PARITY_EN
      PARITY:  txd_d = par_q;
`endif
      STOP:    txd_d = 1'b1;
      default: txd_d = UART_IDLE_LEVEL;
    endcase
  end

  // State, timers and output registers; reset aborts any frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= UART_IDLE_LEVEL;
      busy_q  <= 1'b0;
`ifdef UART_TX_MODEL_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
`ifdef UART_TX_MODEL_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_model.sv
// tb_uart_tx_model: frame-level model plus serial receiver for uart_tx_model.
// Honours UART_TX_MODEL_PARITY_EN the same way as the design.
module tb_uart_tx_model;

  localparam int CPB   = 10;
  localparam int DEPTH = 16;
  localparam int SB    = 1;
`ifdef UART_TX_MODEL_PARITY_EN
  localparam int P     = 1;
`else
  localparam int P     = 0;
`endif
  localparam int FBITS = 1 + 8 + P + SB;
  localparam int FLEN  = FBITS * CPB;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_en;
  logic       uart_txd;
  logic       busy;
  logic [4:0] fifo_count;

  uart_tx_model_if #(.PAYLOAD_BITS(8)) wr_if ();

  uart_tx_model #(
    .BIT_RATE     (100_000),
    .CLK_HZ       (1_000_000),
    .PAYLOAD_BITS (8),
    .STOP_BITS    (SB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_en      (tx_en),
    .wr         (wr_if),
    .uart_txd   (uart_txd),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mk_frame(input logic [7:0] b);
    logic [15:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_TX_MODEL_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  logic [7:0]  m_q[$];
  logic [7:0]  rx_exp[$];
  logic [7:0]  rx_log[$];
  logic        m_valid = 1'b0;
  logic        m_act   = 1'b0;
  int          m_t     = 0;
  logic [15:0] m_frame = '1;
  logic        e_txd   = 1'b1;
  logic        e_busy  = 1'b0;
  int          e_count = 0;
  logic        e_ready = 1'b1;

  logic        rx_on   = 1'b0;
  int          rx_cnt  = 0;
  logic [15:0] rx_bits = '1;

  int          busy_cyc  = 0;
  int          busy_rise = 0;
  logic        busy_prev = 1'b0;

  // Compare, receive, then advance the frame model for the coming edge.
  always @(negedge clk) begin
    logic       push_ok;
    logic [7:0] b;
    int         idx;
    if (m_valid) begin
      chk("txd", uart_txd, e_txd);
      chk("busy", busy, e_busy);
      chk("fifo_count", fifo_count, e_count);
      chk("wr_ready", wr_if.wr_ready, e_ready);
    end
    if (busy === 1'b1) busy_cyc++;
    if (busy === 1'b1 && busy_prev !== 1'b1) busy_rise++;
    busy_prev = busy;

    if (reset) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (uart_txd === 1'b0) begin
        rx_on  = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        idx          = rx_cnt / CPB;
        rx_bits[idx] = uart_txd;
        if (idx == FBITS - 1) begin
          rx_on = 1'b0;
          b     = rx_bits[8:1];
          chk("rx_start", rx_bits[0], 1'b0);
          for (int s = 0; s < SB; s++)
            chk("rx_stop", rx_bits[9 + P + s], 1'b1);
`ifdef UART_TX_MODEL_PARITY_EN
          chk("rx_parity", rx_bits[9], ^b);
`endif
          if (rx_exp.size() == 0) begin
            chk("rx_unexpected", 1, 0);
          end else begin
            chk("rx_byte", b, rx_exp.pop_front());
          end
          rx_log.push_back(b);
        end
      end
    end

    if (reset) begin
      m_q.delete();
      rx_exp.delete();
      m_act   = 1'b0;
      m_t     = 0;
      e_txd   = 1'b1;
      e_busy  = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      e_txd   = m_act ? m_frame[m_t / CPB] : 1'b1;
      e_busy  = m_act;
      push_ok = wr_if.wr_valid && (m_q.size() < DEPTH);
      if (m_act) begin
        m_t++;
        if (m_t == FLEN) m_act = 1'b0;
      end
      if (!m_act && tx_en && m_q.size() > 0) begin
        b       = m_q.pop_front();
        m_frame = mk_frame(b);
        m_t     = 0;
        m_act   = 1'b1;
        rx_exp.push_back(b);
      end
      if (push_ok) m_q.push_back(wr_if.wr_data);
    end
    e_count = m_q.size();
    e_ready = (m_q.size() < DEPTH);
  end

  task automatic go_cyc(input int t);
    int k;
    k = t - cyc;
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [7:0] b, output int e);
    wr_if.wr_valid = 1'b1;
    wr_if.wr_data  = b;
    @(posedge clk);
    #1;
    e = cyc;
    wr_if.wr_valid = 1'b0;
  endtask

  task automatic wait_rx(input string nm, input int n, input int budget);
    int k;
    k = 0;
    while (rx_log.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(nm, rx_log.size() >= n, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, e;
    logic [15:0] exp1;
    logic [7:0]  d[17];
    logic [7:0]  hi[3];

    reset          = 1'b1;
    tx_en          = 1'b0;
    wr_if.wr_valid = 1'b0;
    wr_if.wr_data  = '0;
    gap(3);
    chk("rst_txd", uart_txd, 1'b1);
    chk("rst_ready", wr_if.wr_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", fifo_count, 0);
    reset = 1'b0;
    tx_en = 1'b1;
    gap(5);

    // single byte, exact timing
    rx_log.delete();
    busy_cyc = 0;
    push1(8'h55, n);
`ifdef UART_TX_MODEL_PARITY_EN
    exp1 = {5'h1f, 1'b1, 1'b0, 8'h55, 1'b0};
`else
    exp1 = {6'h3f, 1'b1, 8'h55, 1'b0};
`endif
    go_cyc(n + 1);
    chk("t1_pre_txd", uart_txd, 1'b1);
    go_cyc(n + 2);
    chk("t1_start_edge", uart_txd, 1'b0);
    for (int i = 0; i < FBITS; i++) begin
      go_cyc(n + 2 + i * CPB + CPB / 2);
      chk("t1_bit", uart_txd, exp1[i]);
    end
    go_cyc(n + 1 + FLEN);
    chk("t1_busy_last", busy, 1'b1);
    go_cyc(n + 2 + FLEN);
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_busy_len", busy_cyc, FLEN);
    chk("t1_rx_n", rx_log.size(), 1);
    if (rx_log.size() > 0) chk("t1_rx", rx_log[0], 8'h55);
    gap(20);

    // "HI\n" back to back
    rx_log.delete();
    busy_cyc  = 0;
    busy_rise = 0;
    hi[0] = 8'h48;
    hi[1] = 8'h49;
    hi[2] = 8'h0a;
    for (int i = 0; i < 3; i++) push1(hi[i], e);
    wait_rx("t2_timeout", 3, 4 * FLEN);
    gap(20);
    chk("t2_busy_len", busy_cyc, 3 * FLEN);
    chk("t2_one_burst", busy_rise, 1);
    for (int i = 0; i < 3; i++)
      if (rx_log.size() > i) chk("t2_rx", rx_log[i], hi[i]);

    // fill FIFO with tx disabled
    rx_log.delete();
    tx_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      d[i] = 8'($urandom);
      push1(d[i], e);
    end
    chk("t3_count", fifo_count, 16);
    chk("t3_ready", wr_if.wr_ready, 1'b0);
    tx_en = 1'b1;
    gap(1);
    chk("t3_ready_pop", wr_if.wr_ready, 1'b1);
    chk("t3_count_pop", fifo_count, 15);
    wait_rx("t3_timeout", 16, 17 * FLEN);
    for (int i = 0; i < 16; i++)
      if (rx_log.size() > i) chk("t3_rx", rx_log[i], d[i]);
    gap(20);

    // tx_en drop inside first of three frames
    rx_log.delete();
    for (int i = 0; i < 3; i++) begin
      d[i] = 8'($urandom);
      push1(d[i], e);
      if (i == 0) n = e;
    end
    go_cyc(n + 30);
    tx_en = 1'b0;
    gap(FLEN + 20);
    chk("t4_count", fifo_count, 2);
    chk("t4_busy", busy, 1'b0);
    chk("t4_txd", uart_txd, 1'b1);
    chk("t4_rx_n", rx_log.size(), 1);
    tx_en = 1'b1;
    wait_rx("t4_timeout", 3, 3 * FLEN);
    for (int i = 0; i < 3; i++)
      if (rx_log.size() > i) chk("t4_rx", rx_log[i], d[i]);
    gap(20);

    // reset during data bit 3
    rx_log.delete();
    push1(8'($urandom), n);
    push1(8'($urandom), e);
    go_cyc(n + 2 + 4 * CPB + 3);
    reset = 1'b1;
    gap(1);
    chk("t5_txd", uart_txd, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_count", fifo_count, 0);
    reset = 1'b0;
    gap(3 * FLEN);
    chk("t5_no_rx", rx_log.size(), 0);

    // 8'h07: parity bit and frame length
    rx_log.delete();
    busy_cyc = 0;
    push1(8'h07, n);
`ifdef UART_TX_MODEL_PARITY_EN
    go_cyc(n + 2 + 9 * CPB + CPB / 2);
    chk("t6_parity", uart_txd, 1'b1);
    go_cyc(n + 2 + FLEN + 5);
    chk("t6_len", busy_cyc, 110);
`else
    go_cyc(n + 2 + FLEN + 5);
    chk("t6_len", busy_cyc, 100);
`endif
    chk("t6_rx_n", rx_log.size(), 1);
    if (rx_log.size() > 0) chk("t6_rx", rx_log[0], 8'h07);

    // random pushes and tx_en toggles
    for (int i = 0; i < 3000; i++) begin
      wr_if.wr_valid = ($urandom_range(0, 3) == 0);
      wr_if.wr_data  = 8'($urandom);
      if ($urandom_range(0, 199) == 0) tx_en = ~tx_en;
      @(posedge clk);
      #1;
    end
    wr_if.wr_valid = 1'b0;
    tx_en          = 1'b1;
    n = 0;
    while ((busy !== 1'b0 || fifo_count != 0) && n < 20 * FLEN) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_timeout", (busy === 1'b0) && (fifo_count == 0), 1'b1);
    gap(5);
    chk("drain_rx_left", rx_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
